// File: rtl/sample_dispatch_pkg.sv
// Shared types and defaults for the sample dispatcher: FSM state encoding,
// default sizing constants and the sample type at default width.
package sample_dispatch_pkg;

  localparam int NCORES_DEF = 23;
  localparam int DW_DEF     = 31;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SERVE = 2'd1,
    STALL = 2'd2
  } state_t;

  typedef logic signed [DW_DEF-1:0] sample_t;

  // Index width for an n-entry vector, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_dispatch_rr_arbiter.sv
// Round-robin picker: selects the first asserted request at or above ptr,
// wrapping from N-1 back to 0. Purely combinational.
module rr_arbiter
  import sample_dispatch_pkg::*;
#(
  parameter int N  = NCORES_DEF,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW:0] cand;
  logic        found;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req[cand[IW-1:0]]) begin
        found                = 1'b1;
        grant[cand[IW-1:0]]  = 1'b1;
        idx                  = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/sample_dispatch.sv
// ADC sample FIFO dispatched to NCORES cores by a round-robin arbiter with
// registered one-hot grants. Optional counters under SAMPLE_DISPATCH_STATS_EN.
module sample_dispatch
  import sample_dispatch_pkg::*;
#(
  parameter int NCORES = NCORES_DEF,
  parameter int DW     = DW_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     adc_data,
  input  logic              adc_valid,
  output logic              adc_ready,
  input  logic [NCORES-1:0] req_in,
  output logic [DW-1:0]     core_data,
  output logic [NCORES-1:0] core_grant,
  output logic              overflow
`ifdef SAMPLE_DISPATCH_STATS_EN
  ,
  output logic [31:0]       grant_count,
  output logic [15:0]       drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = idx_width(NCORES);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_next;
  logic [IW-1:0]     rr_ptr, arb_idx;
  logic [NCORES-1:0] req_masked, arb_grant, grant_next;
  logic              grant_en, pop, push, drop, full;
  state_t            state, state_next;

  // A core whose grant is on the outputs this cycle cannot be picked again.
  assign req_masked = req_in & ~core_grant;

  rr_arbiter #(.N(NCORES), .IW(IW)) u_arb (
    .req   (req_masked),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign pop        = grant_en;
  assign full       = (count == (AW+1)'(DEPTH));
  // A pop frees the slot in the same cycle, so a full FIFO still accepts then.
  assign adc_ready  = !full || pop;
  assign push       = adc_valid && adc_ready;
  assign drop       = adc_valid && !adc_ready;
  assign grant_next = pop ? arb_grant : '0;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNT_ONE;
    else if (!push && pop) count_next = count - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    if (count_next == '0)                state_next = EMPTY;
    else if (|(req_in & ~grant_next))    state_next = SERVE;
    else                                 state_next = STALL;
  end

  // Contents only become visible through count, so only count needs EMPTY.
  always_comb begin
    grant_en = (state != EMPTY) && (|req_masked);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // already define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= adc_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_grant <= '0;
      core_data  <= '0;
      rr_ptr     <= '0;
      overflow   <= 1'b0;
    end else begin
      core_grant <= grant_next;
      if (pop) begin
        core_data <= mem[rd_ptr];
        rr_ptr    <= (arb_idx == IW'(NCORES-1)) ? '0 : arb_idx + IW'(1);
      end
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef SAMPLE_DISPATCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_count <= '0;
      drop_count  <= '0;
    end else begin
      if (pop && grant_count != '1) grant_count <= grant_count + 32'd1;
      if (drop && drop_count != '1) drop_count  <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sample_dispatch.sv
// Scoreboard bench for sample_dispatch: a queue-based reference model predicts
// grants and handshakes; a negedge monitor compares every cycle's outputs.
module tb_sample_dispatch;
  import sample_dispatch_pkg::*;

  localparam int NC = NCORES_DEF;
  localparam int DW = DW_DEF;
  localparam int DP = DEPTH_DEF;

  typedef struct {
    int            due;
    int            core;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          adc_valid = 1'b0;
  logic          adc_ready;
  logic [NC-1:0] req_in = '0;
  logic [DW-1:0] core_data;
  logic [NC-1:0] core_grant;
  logic          overflow;
`ifdef SAMPLE_DISPATCH_STATS_EN
  logic [31:0]   grant_count;
  logic [15:0]   drop_count;
`endif

  sample_dispatch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .adc_ready  (adc_ready),
    .req_in     (req_in),
    .core_data  (core_data),
    .core_grant (core_grant),
    .overflow   (overflow)
`ifdef SAMPLE_DISPATCH_STATS_EN
    ,
    .grant_count(grant_count),
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain queue of samples plus arbitration bookkeeping.
  logic [DW-1:0] m_q [$];
  int            m_rr;
  int            m_mask;
  bit            m_ovf;
  int            m_grants;
  int            m_drops;
  exp_t          sb [$];
  logic [DW-1:0] last_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    sb.delete();
    m_rr     = 0;
    m_mask   = -1;
    m_ovf    = 1'b0;
    m_grants = 0;
    m_drops  = 0;
    last_exp = '0;
  endtask

  // One clock cycle of stimulus, with the model deciding what that cycle does.
  task automatic step(input bit v, input sample_t d, input logic [NC-1:0] r);
    bit pop;
    bit exp_ready;
    int sel;
    int k;
    @(posedge clk);
    #1;
    adc_valid = v;
    adc_data  = d;
    req_in    = r;
    check("overflow", overflow, m_ovf);
    pop = 1'b0;
    sel = 0;
    if (m_q.size() > 0) begin
      for (int i = 0; i < NC; i++) begin
        k = (m_rr + i) % NC;
        if (!pop && r[k] && k != m_mask) begin
          pop = 1'b1;
          sel = k;
        end
      end
    end
    exp_ready = (m_q.size() < DP) || pop;
    #1;
    check("adc_ready", adc_ready, exp_ready);
    if (pop) begin
      sb.push_back('{due: cyc + 1, core: sel, data: m_q.pop_front()});
      m_rr   = (sel + 1) % NC;
      m_mask = sel;
      m_grants++;
    end else begin
      m_mask = -1;
    end
    if (v) begin
      if (exp_ready) m_q.push_back(d);
      else begin
        m_ovf = 1'b1;
        m_drops++;
      end
    end
  endtask

  task automatic idle(input int n, input logic [NC-1:0] r);
    for (int i = 0; i < n; i++) step(1'b0, '0, r);
  endtask

  // Asserts reset between edges and checks that outputs clear at once.
  task automatic apply_reset();
    rst_n     = 1'b0;
    adc_valid = 1'b0;
    adc_data  = '0;
    req_in    = '0;
    model_clear();
    #1;
    check("rst_grant", core_grant, '0);
    check("rst_data", core_data, '0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_ready", adc_ready, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [NC-1:0] eg;
    exp_t e;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      check("missed_grant", '0, 64'(e.core + 1));
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e  = sb.pop_front();
      eg = '0;
      eg[e.core] = 1'b1;
      check("grant", core_grant, eg);
      check("grant_data", core_data, e.data);
      last_exp = e.data;
    end else begin
      check("no_grant", core_grant, '0);
      check("held_data", core_data, last_exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC-1:0] all_req;
    logic [NC-1:0] r;
    logic [NC-1:0] one;
    all_req = '1;
    one     = NC'(1);

    @(posedge clk);
    #2 apply_reset();

    // Three samples, no requests: FIFO parks in STALL with no grant.
    step(1'b1, 5, '0);
    step(1'b1, -7, '0);
    step(1'b1, 9, '0);
    step(1'b0, '0, '0);
    check("fsm_stall", dut.state, STALL);

    // Cores 3 and 0 request together from rr_ptr 0: core 0 then core 3.
    step(1'b0, '0, (one << 3) | one);
    step(1'b0, '0, (one << 3) | one);
    idle(2, '0);
    idle(3, one << 7);
    idle(2, '0);

    // All cores request while samples stream in one per cycle.
    @(posedge clk);
    #2 apply_reset();
    for (int i = 0; i < NC; i++) step(1'b1, sample_t'(100 + i), all_req);
    idle(3, all_req);
    idle(2, '0);

    // Fill past depth, then write and pop together while full, then drain.
    @(posedge clk);
    #2 apply_reset();
    for (int i = 1; i <= DP + 1; i++) step(1'b1, sample_t'(i), '0);
    step(1'b1, -100, one << 2);
    idle(DP + 4, all_req);
    idle(2, '0);

    // Core 5 holds its request three cycles with two samples queued.
    @(posedge clk);
    #2 apply_reset();
    step(1'b1, -1, '0);
    step(1'b1, -2, '0);
    idle(3, one << 5);
    idle(3, '0);

    // Reset lands while a grant is on the outputs with samples still queued.
    @(posedge clk);
    #2 apply_reset();
    for (int i = 0; i < 4; i++) step(1'b1, sample_t'(40 + i), '0);
    step(1'b0, '0, one << 1);
    @(posedge clk);
    #2;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      check("pre_reset_grant", core_grant, one << sb[0].core);
      check("pre_reset_data", core_data, sb[0].data);
    end else begin
      check("pre_reset_expected", 64'(sb.size()), 64'd1);
    end
    apply_reset();
    idle(4, all_req);
    step(1'b1, 42, all_req);
    idle(3, all_req);
    idle(2, '0);

    // Randomised traffic against the model.
    @(posedge clk);
    #2 apply_reset();
    for (int i = 0; i < 400; i++) begin
      r = NC'($urandom & $urandom);
      if (i % 97 < 30) r = '0;
      step(1'(($urandom_range(0, 3) != 0)), sample_t'($urandom), r);
    end
    idle(DP * 2, all_req);
    idle(3, '0);

    @(posedge clk);
    #1;
`ifdef SAMPLE_DISPATCH_STATS_EN
    check("grant_count", grant_count, 64'(m_grants));
    check("drop_count", drop_count, 64'(m_drops));
`endif
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("model_empty", 64'(m_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_dispatch.md
SAMPLE_DISPATCH -- requirements
Module: sample_dispatch

Interface
REQ-001 Parameter NCORES, default 23: number of processing cores served.
REQ-002 Parameter DW, default 31: signed sample width.
REQ-003 Parameter DEPTH, default 16, power of two: sample FIFO depth.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port adc_data, input, DW: signed ADC sample from the upstream source.
REQ-007 Port adc_valid, input, 1: adc_data is valid this cycle.
REQ-008 Port adc_ready, output, 1: FIFO can accept a sample; high when not full.
REQ-009 Port req_in, input, NCORES: per-core level request for one sample.
REQ-010 Port core_data, output, DW: sample delivered with the grant.
REQ-011 Port core_grant, output, NCORES: one-hot, single-cycle delivery strobe.
REQ-012 Port overflow, output, 1: sticky flag, set when a sample is dropped.

Function
REQ-013 A sample SHALL be written when adc_valid is high and adc_ready is high; adc_valid while full SHALL drop the sample and set overflow.
REQ-014 FSM states SHALL be EMPTY, SERVE and STALL.
- EMPTY: FIFO empty.
- SERVE: FIFO non-empty and at least one request pending.
- STALL: FIFO non-empty and no request pending.
REQ-015 Transitions SHALL be evaluated every cycle from the next-state FIFO count and the masked request vector.
REQ-016 In SERVE, a round-robin arbiter SHALL pick the first requesting core at or above rr_ptr, wrapping from NCORES-1 to 0.
REQ-017 On a grant, core_grant[k] SHALL pulse for exactly one cycle, core_data SHALL carry the FIFO head, the head SHALL pop, and rr_ptr SHALL become k+1 mod NCORES.
REQ-018 Latency: a request seen in cycle t with a non-empty FIFO SHALL be granted no earlier than cycle t+1 (registered outputs). With all other requests idle, it SHALL be granted exactly at t+1.
REQ-019 At most one grant SHALL be issued per cycle; the grant order SHALL be starvation-free.
REQ-020 A core granted in cycle t SHALL be masked in cycle t+1, so a request still held one cycle later does not double-grant.
REQ-021 core_data SHALL hold its last value when no grant is issued; core_grant SHALL be all zero.
REQ-022 A write into an empty FIFO SHALL be grantable no earlier than the following cycle (no fall-through).
REQ-023 A simultaneous write and pop at full SHALL be accepted, with the count unchanged.
REQ-024 A simultaneous write and pop with exactly one entry SHALL pop the old head and keep the new sample.
REQ-025 FIFO read and write pointers SHALL wrap modulo DEPTH; the count SHALL be log2(DEPTH)+1 bits wide.
REQ-026 Samples SHALL pass through bit-exact; no sign conversion or arithmetic.

Reset
REQ-027 rst_n low SHALL immediately force:
- FSM to EMPTY
- FIFO to empty
- rr_ptr to 0
- core_grant to 0
- core_data to 0
- overflow to 0
- adc_ready to 1
REQ-028 Reset asserted mid-grant SHALL discard the FIFO contents; no grant SHALL appear in the first cycle after release.

Configuration
REQ-029 With macro SAMPLE_DISPATCH_STATS_EN defined:
- output ports grant_count[31:0] and drop_count[15:0] SHALL exist.
- grant_count SHALL count grants; drop_count SHALL count dropped samples.
- both counters SHALL saturate and SHALL reset to 0.
REQ-030 Without SAMPLE_DISPATCH_STATS_EN, those ports and counters SHALL be absent and all other behaviour identical.

Structure
REQ-031 Package sample_dispatch_pkg SHALL hold:
- the FSM state enum
- default constants NCORES_DEF=23, DW_DEF=31, DEPTH_DEF=16
- the sample typedef (signed DW)
REQ-032 The round-robin arbiter SHALL be a sub-module rr_arbiter (request, pointer in; one-hot grant and index out); the FIFO stays inline.

Verification
REQ-033 Reset, then push samples 5, -7, 9 with no requests: state STALL after the last write; no grant; adc_ready=1.
REQ-034 FIFO holds 5, -7, 9; req_in[3] and req_in[0] rise together with rr_ptr=0:
- core 0 gets 5 at t+1.
- core 3 gets -7 at t+2.
- the FIFO holds 9 afterward.
REQ-035 All 23 requests held high with 23 samples streamed in one per cycle: grants go to cores 0,1,...,22 in order, one per cycle, and no core is granted twice.
REQ-036 Write 17 samples (DEPTH=16) with no requests:
- adc_ready=0 after the 16th write.
- the 17th sample is dropped and overflow=1 (drop_count=1 with STATS_EN).
- the FIFO holds samples 1..16.
REQ-037 Core 5 holds req_in[5] for 3 cycles with 2 samples queued: exactly 2 grants to core 5, with one masked cycle between them.
REQ-038 rst_n pulsed low while the FIFO holds 4 samples and a grant is active: outputs go to 0 asynchronously and, after release, no grant occurs until a new sample is written.
